// File: rtl/struct_assign_arb.sv
// Round-robin arbiter that shares one registered struct field-assign stage among NUM_REQ requesters.
// Define STRUCT_ASSIGN_ARB_STATS_EN to add per-requester saturating grant counters on grant_count.
module struct_assign_arb #(
  parameter int NUM_REQ       = 4,
  parameter int STRUCT_WIDTH  = 16,
  parameter int ASSIGN_OFFSET = 0,
  parameter int ASSIGN_SIZE   = 4,
  localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*STRUCT_WIDTH-1:0] s_struct_axis_tdata,
  input  logic [NUM_REQ-1:0]              s_struct_axis_tvalid,
  output logic [NUM_REQ-1:0]              s_struct_axis_tready,
  input  logic [NUM_REQ*ASSIGN_SIZE-1:0]  s_assignv_axis_tdata,
  input  logic [NUM_REQ-1:0]              s_assignv_axis_tvalid,
  output logic [NUM_REQ-1:0]              s_assignv_axis_tready,
  output logic [STRUCT_WIDTH-1:0]         m_struct_axis_tdata,
  output logic [ID_WIDTH-1:0]             m_struct_axis_tdest,
  output logic                            m_struct_axis_tvalid,
  input  logic                            m_struct_axis_tready
`ifdef STRUCT_ASSIGN_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           grant_count
`endif
);

  logic [NUM_REQ-1:0]      elig_p0;
  logic                    can_load_p0;
  logic                    found_p0;
  logic                    grant_vld_p0;
  logic [ID_WIDTH-1:0]     grant_p0;
  logic [STRUCT_WIDTH-1:0] load_data_p0;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [STRUCT_WIDTH-1:0] data_p1;
  logic [ID_WIDTH-1:0]     dest_p1;
  logic                    vld_p1;

  // Returns {found, index} of the first eligible requester at or after ptr, wrapping.
  function automatic logic [ID_WIDTH:0] pick_first(input logic [NUM_REQ-1:0] elig,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0] res;
    int idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[idx]) res = {1'b1, idx[ID_WIDTH-1:0]};
    end
    return res;
  endfunction

  function automatic logic [STRUCT_WIDTH-1:0] insert_field(input logic [STRUCT_WIDTH-1:0] s,
                                                          input logic [ASSIGN_SIZE-1:0] v);
    logic [STRUCT_WIDTH-1:0] r;
    r = s;
    r[ASSIGN_OFFSET +: ASSIGN_SIZE] = v;
    return r;
  endfunction

  // Stage p0: eligibility, grant selection and input handshake (combinational)
  always_comb begin
    elig_p0      = s_struct_axis_tvalid & s_assignv_axis_tvalid;
    can_load_p0  = !vld_p1 || m_struct_axis_tready;
    {found_p0, grant_p0} = pick_first(elig_p0, rr_ptr);
    grant_vld_p0 = found_p0 && can_load_p0 && rst;
    load_data_p0 = insert_field(s_struct_axis_tdata[int'(grant_p0)*STRUCT_WIDTH +: STRUCT_WIDTH],
                                s_assignv_axis_tdata[int'(grant_p0)*ASSIGN_SIZE +: ASSIGN_SIZE]);
    s_struct_axis_tready  = '0;
    s_assignv_axis_tready = '0;
    if (grant_vld_p0) begin
      s_struct_axis_tready[grant_p0]  = 1'b1;
      s_assignv_axis_tready[grant_p0] = 1'b1;
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      dest_p1 <= '0;
      rr_ptr  <= '0;
    end else if (grant_vld_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data_p0;
      dest_p1 <= grant_p0;
      rr_ptr  <= (int'(grant_p0) == NUM_REQ - 1) ? '0 : grant_p0 + 1'b1;
    end else if (m_struct_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_struct_axis_tdata  = data_p1;
  assign m_struct_axis_tdest  = dest_p1;
  assign m_struct_axis_tvalid = vld_p1;

`ifdef STRUCT_ASSIGN_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_count <= '0;
    end else if (grant_vld_p0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(grant_p0) == i && grant_count[i*16 +: 16] != 16'hFFFF)
          grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_struct_assign_arb.sv
// Self-checking bench for struct_assign_arb (NUM_REQ=4, 16-bit struct, 4-bit field at bit 0).
// Directed scenarios plus random traffic compared against a round-robin reference model.
module tb_struct_assign_arb;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int AS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*SW-1:0] st_data;
  logic [N-1:0]  st_vld;
  logic [N-1:0]  st_rdy;
  logic [N*AS-1:0] av_data;
  logic [N-1:0]  av_vld;
  logic [N-1:0]  av_rdy;
  logic [SW-1:0] m_data;
  logic [1:0]    m_dest;
  logic          m_vld;
  logic          m_rdy;
`ifdef STRUCT_ASSIGN_ARB_STATS_EN
  logic [N*16-1:0] gcount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            mdl_rr;
  bit            mdl_vld;
  logic [SW-1:0] mdl_data;
  int            mdl_dest;

  always #5 clk = ~clk;

  struct_assign_arb dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_struct_axis_tdata   (st_data),
    .s_struct_axis_tvalid  (st_vld),
    .s_struct_axis_tready  (st_rdy),
    .s_assignv_axis_tdata  (av_data),
    .s_assignv_axis_tvalid (av_vld),
    .s_assignv_axis_tready (av_rdy),
    .m_struct_axis_tdata   (m_data),
    .m_struct_axis_tdest   (m_dest),
    .m_struct_axis_tvalid  (m_vld),
    .m_struct_axis_tready  (m_rdy)
`ifdef STRUCT_ASSIGN_ARB_STATS_EN
    ,
    .grant_count           (gcount)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_rr   = 0;
    mdl_vld  = 0;
    mdl_data = '0;
    mdl_dest = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_vld"},  64'(m_vld),  64'(mdl_vld));
    chk({tag, "_data"}, 64'(m_data), 64'(mdl_data));
    chk({tag, "_dest"}, 64'(m_dest), 64'(mdl_dest));
  endtask

  // One clock cycle: inputs are already driven (called just after a falling edge).
  task automatic tick(input string tag);
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    #1;
    g = -1;
    if (!mdl_vld || m_rdy) begin
      for (int k = 0; k < N; k++) begin
        idx = (mdl_rr + k) % N;
        if (g < 0 && st_vld[idx] && av_vld[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk({tag, "_srdy"}, 64'(st_rdy), 64'(exp_rdy));
    chk({tag, "_ardy"}, 64'(av_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      mdl_data      = st_data[g*SW +: SW];
      mdl_data[3:0] = av_data[g*AS +: AS];
      mdl_dest      = g;
      mdl_vld       = 1;
      mdl_rr        = (g + 1) % N;
    end else if (m_rdy) begin
      mdl_vld = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_vld",  64'(m_vld),  64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_dest", 64'(m_dest), 64'd0);
    chk("rst_srdy", 64'(st_rdy), 64'd0);
    chk("rst_ardy", 64'(av_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    st_data = '0; st_vld = '0; av_data = '0; av_vld = '0; m_rdy = 1'b1;
    model_reset();
    @(negedge clk);
    // All requesters eligible while in reset: readies must stay low
    st_vld = '1; av_vld = '1;
    do_reset();

    // Single requester
    do_reset();
    st_vld = 4'b0100; av_vld = 4'b0100;
    st_data = '0; st_data[47:32] = 16'hABCD;
    av_data = '0; av_data[11:8] = 4'h5;
    tick("single");
    chk("single_lit_data", 64'(m_data), 64'hABC5);
    chk("single_lit_dest", 64'(m_dest), 64'd2);
    st_vld = '0; av_vld = '0;
    tick("single_drain");

    // Round-robin, all continuously eligible
    do_reset();
    st_data = 64'h4444_3333_2222_1111; av_data = 16'hDCBA;
    st_vld = '1; av_vld = '1;
    for (int i = 0; i < 6; i++) begin
      tick("rr");
      chk("rr_lit_dest", 64'(m_dest), 64'(i % 4));
    end

    // Half-valid requester 1 never granted until its assign value arrives
    do_reset();
    st_vld = 4'b1010; av_vld = 4'b1000;
    tick("half");
    chk("half_lit_dest", 64'(m_dest), 64'd3);
    tick("half2");
    av_vld = 4'b1010;
    tick("half3");
    chk("half_lit_dest3", 64'(m_dest), 64'd1);

    // Back-pressure
    do_reset();
    st_vld = 4'b0001; av_vld = 4'b0001; m_rdy = 1'b1;
    tick("bp_load");
    st_vld = 4'b0110; av_vld = 4'b0110; m_rdy = 1'b0;
    for (int i = 0; i < 5; i++) tick("bp_hold");
    m_rdy = 1'b1;
    tick("bp_release");
    chk("bp_lit_dest", 64'(m_dest), 64'd1);

    // Reset asserted mid-operation between clock edges
    do_reset();
    st_vld = '1; av_vld = '1; m_rdy = 1'b1;
    tick("mid_a");
    tick("mid_b");
    m_rdy = 1'b0;
    do_reset();
    m_rdy = 1'b1;
    tick("mid_after");
    chk("mid_lit_dest", 64'(m_dest), 64'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st_vld  = N'($urandom);
      av_vld  = N'($urandom);
      st_data = {$urandom, $urandom};
      av_data = 16'($urandom);
      m_rdy   = ($urandom % 4) != 0;
      tick("rand");
    end

`ifdef STRUCT_ASSIGN_ARB_STATS_EN
    do_reset();
    st_vld = 4'b0001; av_vld = 4'b0001; m_rdy = 1'b1;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    chk("stats_req0", 64'(gcount[15:0]), 64'hFFFF);
    chk("stats_rest", 64'(gcount[63:16]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
